// File: rtl/serial_frame_receive.sv
// rtl/serial_frame_receive.sv - byte-stream deframer committing fixed-length payloads atomically
// Raw or sync-framed input with optional XOR checksum, inter-byte timeout and saturating error counters.
module serial_frame_receive #(
  parameter int         PAYLOAD_BYTES  = 44,
  parameter bit         FRAMED         = 1'b0,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter bit         CHECKSUM_EN    = 1'b0,
  parameter int         TIMEOUT_CYCLES = 8388608
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       load_flag,
  output logic                       load_pulse,
  output logic                       busy,
  output logic [7:0]                 csum_err_cnt,
  output logic [7:0]                 timeout_cnt
);

  localparam int W         = 8 * PAYLOAD_BYTES;
  localparam int CW        = $clog2(PAYLOAD_BYTES + 1);
  localparam int IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit USE_CHECK = FRAMED && CHECKSUM_EN;

  typedef enum logic [1:0] {IDLE, DATA, CHECK, COMMIT} state_t;

  state_t         state, state_n;
  logic [W-1:0]   shift_buf, shift_buf_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [7:0]     csum, csum_n;
  logic [IW-1:0]  idle_cnt, idle_n;
  logic           commit, csum_err, timeout;

  always_comb begin
    state_n     = state;
    shift_buf_n = shift_buf;
    cnt_n       = cnt;
    csum_n      = csum;
    idle_n      = '0;
    commit      = 1'b0;
    csum_err    = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE, COMMIT: begin
        // A byte landing in the COMMIT cycle is treated exactly like one arriving in IDLE.
        if (state == COMMIT) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
        if (rx_valid) begin
          if (!FRAMED) begin
            shift_buf_n = (shift_buf << 8) | W'(rx_data);
            cnt_n       = CW'(1);
            csum_n      = rx_data;
            state_n     = (PAYLOAD_BYTES == 1) ? COMMIT : DATA;
          end else if (rx_data == SYNC_BYTE) begin
            cnt_n   = '0;
            csum_n  = '0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          shift_buf_n = (shift_buf << 8) | W'(rx_data);
          cnt_n       = cnt + CW'(1);
          csum_n      = csum ^ rx_data;
          if (cnt + CW'(1) == CW'(PAYLOAD_BYTES))
            state_n = USE_CHECK ? CHECK : COMMIT;
        end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          idle_n = idle_cnt + IW'(1);
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            state_n = COMMIT;
          end else begin
            state_n  = IDLE;
            csum_err = 1'b1;
          end
        end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          idle_n = idle_cnt + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shift_buf    <= '0;
      cnt          <= '0;
      csum         <= '0;
      idle_cnt     <= '0;
      payload      <= '0;
      load_flag    <= 1'b0;
      load_pulse   <= 1'b0;
      csum_err_cnt <= '0;
      timeout_cnt  <= '0;
    end else begin
      state      <= state_n;
      shift_buf  <= shift_buf_n;
      cnt        <= cnt_n;
      csum       <= csum_n;
      idle_cnt   <= idle_n;
      load_pulse <= commit;
      if (commit) begin
        payload   <= shift_buf;
        load_flag <= ~load_flag;
      end
      if (csum_err && csum_err_cnt != 8'hFF)
        csum_err_cnt <= csum_err_cnt + 8'd1;
      if (timeout && timeout_cnt != 8'hFF)
        timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

  // Held through the load_pulse cycle so busy drops together with the pulse.
  assign busy = (state != IDLE) || load_pulse;

endmodule
